branch_ctrl: RTL and testbench

Branch resolution controller for the RISC-V core's execute stage. It accepts one branch or jump per handshake and latches its operands. It drives the existing branch_comp comparator, evaluates the condition, computes the target and issues a one-cycle redirect plus a timed IF/ID flush. It also keeps saturating branch/taken counters for performance monitoring.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/branch_ctrl_if.sv | 31 +++
 rtl/branch_comp.sv | 13 +
 rtl/branch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the core.
// Branch funct3 codes and branch controller state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2
  } br_state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// Execute-stage branch handshake and fetch redirect bundle.
// Master is the execute stage / fetch side, slave is branch_ctrl.
interface branch_ctrl_if;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_funct3;
  logic        br_is_jal;
  logic        br_is_jalr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;

  modport master (
    output br_valid, br_funct3, br_is_jal, br_is_jalr,
    output rs1_data, rs2_data, pc, imm,
    input  br_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id
  );

  modport slave (
    input  br_valid, br_funct3, br_is_jal, br_is_jalr,
    input  rs1_data, rs2_data, pc, imm,
    output br_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id
  );
endinterface

// File: rtl/branch_comp.sv
// Branch comparator: equality and signed/unsigned less-than.
// BrUn selects unsigned comparison.
module branch_comp (
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  input  logic        BrUn,
  output logic        BrLT,
  output logic        BrEq
);
  assign BrEq = (DataA == DataB);
  assign BrLT = BrUn ? (DataA < DataB)
                     : ($signed(DataA) < $signed(DataB));
endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage branch resolution: condition, target, redirect,
// timed IF/ID flush and saturating branch/taken counters.
module branch_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_ctrl_if.slave     bus,
  input  logic             clr_cnt,
  output logic             misalign,
  output logic             illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES - 1);

  br_state_e        state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [2:0]       funct3_q;
  logic             jal_q, jalr_q;
  logic [31:0]      rs1_q, rs2_q, pc_q, imm_q;
  logic             redir_q, redir_d;
  logic [31:0]      rpc_q, rpc_d;
  logic             mis_q, mis_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  logic        accept;
  logic        br_lt, br_eq;
  logic        taken, cond_ill;
  logic        jalr_only;
  logic [31:0] sum, target;

  branch_comp u_comp (
    .DataA (rs1_q),
    .DataB (rs2_q),
    .BrUn  (funct3_q[1]),
    .BrLT  (br_lt),
    .BrEq  (br_eq)
  );

  assign accept = bus.br_valid && (state_q == ST_IDLE);

  always_comb begin
    taken    = 1'b0;
    cond_ill = 1'b0;
    if (jal_q || jalr_q) begin
      taken = 1'b1;
    end else begin
      unique case (funct3_q)
        F3_BEQ:  taken = br_eq;
        F3_BNE:  taken = !br_eq;
        F3_BLT:  taken = br_lt;
        F3_BGE:  taken = !br_lt;
        F3_BLTU: taken = br_lt;
        F3_BGEU: taken = !br_lt;
        default: cond_ill = 1'b1;
      endcase
    end
  end

  // JAL wins over JALR when both flags are set
  assign jalr_only = jalr_q && !jal_q;
  assign sum       = (jalr_only ? rs1_q : pc_q) + imm_q;
  assign target    = jalr_only ? {sum[31:1], 1'b0} : sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (accept) state_d = ST_RESOLVE;
      ST_RESOLVE:
        if (taken && !target[1]) state_d = ST_FLUSH;
        else                     state_d = ST_IDLE;
      ST_FLUSH:
        if (fcnt_q == 3'd0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    redir_d = 1'b0;
    mis_d   = 1'b0;
    ill_d   = 1'b0;
    rpc_d   = rpc_q;
    fcnt_d  = fcnt_q;
    if (state_q == ST_RESOLVE) begin
      ill_d = cond_ill;
      if (taken && target[1]) begin
        mis_d = 1'b1;
      end else if (taken) begin
        redir_d = 1'b1;
        rpc_d   = target;
        fcnt_d  = FC_LOAD;
      end
    end else if (state_q == ST_FLUSH && fcnt_q != 3'd0) begin
      fcnt_d = fcnt_q - 3'd1;
    end
  end

  // clear beats a same-cycle increment
  always_comb begin
    bcnt_d = bcnt_q;
    tcnt_d = tcnt_q;
    if (clr_cnt) begin
      bcnt_d = '0;
      tcnt_d = '0;
    end else begin
      if (accept && bcnt_q != '1)  bcnt_d = bcnt_q + 1'b1;
      if (redir_d && tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q   <= '0;
      funct3_q <= '0;
      jal_q    <= 1'b0;
      jalr_q   <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      redir_q  <= 1'b0;
      rpc_q    <= '0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      if (accept) begin
        funct3_q <= bus.br_funct3;
        jal_q    <= bus.br_is_jal;
        jalr_q   <= bus.br_is_jalr;
        rs1_q    <= bus.rs1_data;
        rs2_q    <= bus.rs2_data;
        pc_q     <= bus.pc;
        imm_q    <= bus.imm;
      end
    end
  end

  assign bus.br_ready       = (state_q == ST_IDLE);
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.flush_if       = (state_q == ST_FLUSH);
  assign bus.flush_id       = (state_q == ST_FLUSH);
  assign misalign           = mis_q;
  assign illegal            = ill_q;
  assign branch_cnt         = bcnt_q;
  assign taken_cnt          = tcnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: conditions, targets, flush timing,
// misalign/illegal pulses, counter saturation/clear and mid-flush reset.
module tb_branch_ctrl;
  import riscv_pkg::*;

  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          misalign, illegal;
  logic [CW-1:0] branch_cnt, taken_cnt;

  int          checks = 0;
  int          failures = 0;
  int          exp_bc = 0;
  int          exp_tc = 0;
  logic [31:0] last_pc = '0;

  branch_ctrl_if bus ();

  branch_ctrl #(
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_cnt    (clr_cnt),
    .misalign   (misalign),
    .illegal    (illegal),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic jal,
                       input logic jalr, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] i);
    bus.br_funct3  = f3;
    bus.br_is_jal  = jal;
    bus.br_is_jalr = jalr;
    bus.rs1_data   = a;
    bus.rs2_data   = b;
    bus.pc         = p;
    bus.imm        = i;
    bus.br_valid   = 1'b1;
    @(posedge clk);
    #1 bus.br_valid = 1'b0;
  endtask

  task automatic run_br(input string tag, input logic [2:0] f3,
                        input logic jal, input logic jalr,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i,
                        input logic redir, input logic [31:0] tpc,
                        input logic mis, input logic ill,
                        input logic clr);
    @(negedge clk);
    chk({tag, ".rdy_T"}, bus.br_ready, 1);
    drive(f3, jal, jalr, a, b, p, i);
    exp_bc = sat(exp_bc + 1);
    @(negedge clk);
    chk({tag, ".rdy_T1"}, bus.br_ready, 0);
    chk({tag, ".rv_T1"}, bus.redirect_valid, 0);
    chk({tag, ".bcnt_T1"}, branch_cnt, exp_bc);
    if (clr) clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    if (clr) begin
      exp_bc = 0;
      exp_tc = 0;
    end else if (redir) begin
      exp_tc = sat(exp_tc + 1);
    end
    if (redir) last_pc = tpc;
    chk({tag, ".rv_T2"}, bus.redirect_valid, redir);
    chk({tag, ".fif_T2"}, bus.flush_if, redir);
    chk({tag, ".fid_T2"}, bus.flush_id, redir);
    chk({tag, ".mis_T2"}, misalign, mis);
    chk({tag, ".ill_T2"}, illegal, ill);
    chk({tag, ".rdy_T2"}, bus.br_ready, !redir);
    chk({tag, ".rpc_T2"}, bus.redirect_pc, last_pc);
    chk({tag, ".tcnt"}, taken_cnt, exp_tc);
    chk({tag, ".bcnt"}, branch_cnt, exp_bc);
    if (redir) begin
      for (int k = 1; k < FC; k++) begin
        @(negedge clk);
        chk({tag, ".fif_hold"}, bus.flush_if, 1);
        chk({tag, ".fid_hold"}, bus.flush_id, 1);
        chk({tag, ".rv_hold"}, bus.redirect_valid, 0);
        chk({tag, ".rdy_hold"}, bus.br_ready, 0);
      end
    end
    @(negedge clk);
    chk({tag, ".fif_end"}, bus.flush_if, 0);
    chk({tag, ".rv_end"}, bus.redirect_valid, 0);
    chk({tag, ".mis_end"}, misalign, 0);
    chk({tag, ".ill_end"}, illegal, 0);
    chk({tag, ".rdy_end"}, bus.br_ready, 1);
  endtask

  initial begin
    bus.br_valid   = 1'b0;
    bus.br_funct3  = '0;
    bus.br_is_jal  = 1'b0;
    bus.br_is_jalr = 1'b0;
    bus.rs1_data   = '0;
    bus.rs2_data   = '0;
    bus.pc         = '0;
    bus.imm        = '0;

    #12;
    chk("rst.rv", bus.redirect_valid, 0);
    chk("rst.rpc", bus.redirect_pc, 0);
    chk("rst.fif", bus.flush_if, 0);
    chk("rst.fid", bus.flush_id, 0);
    chk("rst.mis", misalign, 0);
    chk("rst.ill", illegal, 0);
    chk("rst.bcnt", branch_cnt, 0);
    chk("rst.tcnt", taken_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst.rdy", bus.br_ready, 1);

    run_br("beq_t", F3_BEQ, 0, 0, 32'd5, 32'd5, 32'h100, 32'h20,
           1, 32'h120, 0, 0, 0);
    run_br("beq_nt", F3_BEQ, 0, 0, 32'd5, 32'd6, 32'h100, 32'h20,
           0, 32'h0, 0, 0, 0);
    run_br("blt_t", F3_BLT, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h200,
           32'hFFFF_FFF0, 1, 32'h1F0, 0, 0, 0);
    run_br("bltu_nt", F3_BLTU, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h200,
           32'hFFFF_FFF0, 0, 32'h0, 0, 0, 0);
    run_br("bge_t", F3_BGE, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'h300,
           32'h8, 1, 32'h308, 0, 0, 0);
    run_br("bne_nt", F3_BNE, 0, 0, 32'd7, 32'd7, 32'h300, 32'h8,
           0, 32'h0, 0, 0, 0);
    run_br("bgeu_nt", F3_BGEU, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'h300,
           32'h8, 0, 32'h0, 0, 0, 0);
    run_br("jalr_mis", F3_BEQ, 0, 1, 32'h1003, 32'd0, 32'h400, 32'h0,
           0, 32'h0, 1, 0, 0);
    run_br("jalr_ok", F3_BEQ, 0, 1, 32'h1001, 32'd0, 32'h400, 32'h0,
           1, 32'h1000, 0, 0, 0);
    run_br("ill_010", 3'b010, 0, 0, 32'd1, 32'd1, 32'h500, 32'h10,
           0, 32'h0, 0, 1, 0);
    run_br("jal_wrap", 3'b011, 1, 1, 32'h9000, 32'd0, 32'hFFFF_FFF0,
           32'h20, 1, 32'h10, 0, 0, 0);
    run_br("jal_mis", F3_BEQ, 1, 0, 32'd0, 32'd0, 32'h100, 32'h2,
           0, 32'h0, 1, 0, 0);

    for (int n = 0; n < 20; n++)
      run_br("jal_sat", F3_BEQ, 1, 0, 32'd0, 32'd0, 32'h0, 32'h40,
             1, 32'h40, 0, 0, 0);
    chk("sat.tcnt", taken_cnt, CMAX);
    chk("sat.bcnt", branch_cnt, CMAX);

    run_br("clr_redir", F3_BEQ, 1, 0, 32'd0, 32'd0, 32'h0, 32'h4,
           1, 32'h4, 0, 0, 1);

    @(negedge clk);
    drive(F3_BEQ, 1'b1, 1'b0, 32'd0, 32'd0, 32'h800, 32'h80);
    @(negedge clk);
    @(negedge clk);
    chk("arst.fif_pre", bus.flush_if, 1);
    rst_n = 1'b0;
    #1;
    chk("arst.fif", bus.flush_if, 0);
    chk("arst.fid", bus.flush_id, 0);
    chk("arst.rv", bus.redirect_valid, 0);
    chk("arst.rpc", bus.redirect_pc, 0);
    chk("arst.bcnt", branch_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_bc = 0;
    exp_tc = 0;
    last_pc = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post.rdy", bus.br_ready, 1);
      chk("post.rv", bus.redirect_valid, 0);
      chk("post.fif", bus.flush_if, 0);
      chk("post.mis", misalign, 0);
      chk("post.tcnt", taken_cnt, 0);
    end
    run_br("post_beq", F3_BEQ, 0, 0, 32'd9, 32'd9, 32'h40, 32'h10,
           1, 32'h50, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
